dnu_wr_ctrl_gen: RTL and testbench

//   Parametrised write controller for the variable-node IB-map RAM update.

---
 rtl/dnu_wr_ctrl_gen.sv | 129 ++++++++++++
 tb/tb_dnu_wr_ctrl_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dnu_wr_ctrl_gen.sv
// Write controller for the variable-node IB-map RAM update: ROM fetch, banked RAM writes, abort and completion.
// Optional completed-update counter enabled by defining DNU_WR_ITER_CNT_EN.
module dnu_wr_ctrl_gen #(
  parameter int LOAD_CYCLE = 64,
  parameter int BANK_NUM   = 2,
  parameter int FETCH_LAT  = 1,
  parameter int ITER_W     = 8,
  localparam int CW        = $clog2(LOAD_CYCLE)
) (
  input  logic                write_clk,
  input  logic                rstn,
  input  logic                iter_rqst,
  input  logic                iter_termination,
  input  logic [CW:0]         load_len,
  output logic                rom_port_fetch,
  output logic                ram_mux_en,
  output logic                ram_write_en,
  output logic [BANK_NUM-1:0] bank_we,
  output logic [CW-1:0]       wr_addr,
  output logic                iter_update,
  output logic                v3ib_rom_rst,
  output logic [1:0]          busy,
  output logic                iter_done,
  output logic                iter_aborted,
  output logic [2:0]          state,
  output logic [ITER_W-1:0]   iter_cnt
);

  localparam logic [2:0]    S_IDLE     = 3'b000;
  localparam logic [2:0]    S_FETCH    = 3'b001;
  localparam logic [2:0]    S_LOAD     = 3'b010;
  localparam logic [2:0]    S_FINISH   = 3'b100;
  localparam logic [3:0]    FETCH_LAST = 4'(FETCH_LAT - 1);
  localparam logic [3:0]    FETCH_ONE  = 4'd1;
  localparam logic [CW:0]   LEN_MAX    = (CW+1)'(LOAD_CYCLE);
  localparam logic [CW:0]   LEN_ONE    = (CW+1)'(1);
  localparam logic [CW-1:0] ADDR_ONE   = CW'(1);

  logic [2:0]    r_state;
  logic          r_rqst_q;
  logic [3:0]    r_fetch_cnt;
  logic [CW-1:0] r_wr_addr;
  logic [CW:0]   r_len;
  logic          r_done;
  logic          r_aborted;

  logic [2:0]    w_nxt_state;
  logic          w_start;
  logic          w_to_finish;
  logic          w_last_fetch;
  logic          w_last_write;
  logic [CW:0]   w_len_clamped;

  // A level already high when rqst_q clears (e.g. at reset release) still counts as an edge.
  assign w_start       = (r_state == S_IDLE) && iter_rqst && !r_rqst_q && !iter_termination;
  assign w_last_fetch  = (r_fetch_cnt == FETCH_LAST);
  assign w_last_write  = ({1'b0, r_wr_addr} == (r_len - LEN_ONE));
  assign w_len_clamped = ((load_len == '0) || (load_len > LEN_MAX)) ? LEN_MAX : load_len;

  always_comb begin
    w_nxt_state = r_state;
    w_to_finish = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_nxt_state = S_FETCH;
      S_FETCH: begin
        if (iter_termination)  w_to_finish = 1'b1;
        else if (w_last_fetch) w_nxt_state = S_LOAD;
      end
      S_LOAD:   if (iter_termination || w_last_write) w_to_finish = 1'b1;
      S_FINISH: if (!iter_rqst) w_nxt_state = S_IDLE;
      default:  w_nxt_state = S_IDLE;
    endcase
    if (w_to_finish) w_nxt_state = S_FINISH;
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_rqst_q    <= 1'b0;
      r_fetch_cnt <= '0;
      r_wr_addr   <= '0;
      r_len       <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_rqst_q <= iter_rqst;
      r_done   <= w_to_finish;
      // Counters run only while staying in their own state, so every exit (incl. abort) clears them.
      r_fetch_cnt <= ((r_state == S_FETCH) && (w_nxt_state == S_FETCH)) ? r_fetch_cnt + FETCH_ONE : '0;
      r_wr_addr   <= ((r_state == S_LOAD) && (w_nxt_state == S_LOAD)) ? r_wr_addr + ADDR_ONE : '0;
      if (w_start) begin
        r_len     <= w_len_clamped;
        r_aborted <= 1'b0;
      end
      if (w_to_finish && iter_termination) r_aborted <= 1'b1;
    end
  end

`ifdef DNU_WR_ITER_CNT_EN
  localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);
  logic [ITER_W-1:0] r_iter_cnt;

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_iter_cnt <= '0;
    end else if (w_to_finish && !iter_termination && (r_iter_cnt != '1)) begin
      r_iter_cnt <= r_iter_cnt + CNT_ONE;
    end
  end

  assign iter_cnt = r_iter_cnt;
`else
  assign iter_cnt = '0;
`endif

  assign rom_port_fetch = (r_state == S_FETCH) || (r_state == S_LOAD);
  assign iter_update    = rom_port_fetch;
  assign ram_write_en   = (r_state == S_LOAD);
  assign ram_mux_en     = ram_write_en || ((r_state == S_FETCH) && w_last_fetch);
  assign bank_we        = {BANK_NUM{ram_write_en}};
  assign wr_addr        = r_wr_addr;
  assign v3ib_rom_rst   = (r_state == S_IDLE);
  assign busy           = {(r_state == S_FINISH), rom_port_fetch};
  assign iter_done      = r_done;
  assign iter_aborted   = r_aborted;
  assign state          = r_state;

endmodule

// File: tb/tb_dnu_wr_ctrl_gen.sv
// Bench for dnu_wr_ctrl_gen: directed and random updates compared cycle by cycle against a transaction-level trace model.
module tb_dnu_wr_ctrl_gen;

  localparam int LC   = 64;
  localparam int BN   = 2;
  localparam int FL   = 1;
  localparam int IW   = 8;
  localparam int CW   = $clog2(LC);
  localparam int VW   = 3 + 2 + 3 + BN + CW + 4 + IW;
  localparam int CMAX = (1 << IW) - 1;

  // clock / reset
  logic write_clk = 1'b0;
  logic rstn;
  always #5 write_clk = ~write_clk;

  logic          iter_rqst;
  logic          iter_termination;
  logic [CW:0]   load_len;
  logic          rom_port_fetch, ram_mux_en, ram_write_en;
  logic [BN-1:0] bank_we;
  logic [CW-1:0] wr_addr;
  logic          iter_update, v3ib_rom_rst;
  logic [1:0]    busy;
  logic          iter_done, iter_aborted;
  logic [2:0]    state;
  logic [IW-1:0] iter_cnt;

  dnu_wr_ctrl_gen #(.LOAD_CYCLE(LC), .BANK_NUM(BN), .FETCH_LAT(FL), .ITER_W(IW)) dut (
    .write_clk(write_clk), .rstn(rstn), .iter_rqst(iter_rqst), .iter_termination(iter_termination),
    .load_len(load_len), .rom_port_fetch(rom_port_fetch), .ram_mux_en(ram_mux_en),
    .ram_write_en(ram_write_en), .bank_we(bank_we), .wr_addr(wr_addr), .iter_update(iter_update),
    .v3ib_rom_rst(v3ib_rom_rst), .busy(busy), .iter_done(iter_done), .iter_aborted(iter_aborted),
    .state(state), .iter_cnt(iter_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int m_cnt    = 0;   // completed, non-aborted updates since reset
  bit m_ab     = 1'b0; // outcome of the last update

  // Phase: 0 idle, 1 fetch, 2 load, 3 finish.
  function automatic logic [VW-1:0] exp_vec(int ph, int addr, bit mux, bit done, bit ab);
    logic [2:0] st;
    logic [1:0] bz;
    bit act, ld, rr;
    logic [IW-1:0] cnt;
    act = (ph == 1) || (ph == 2);
    ld  = (ph == 2);
    rr  = (ph == 0);
    case (ph)
      0:       st = 3'b000;
      1:       st = 3'b001;
      2:       st = 3'b010;
      default: st = 3'b100;
    endcase
    bz = (ph == 3) ? 2'b10 : (act ? 2'b01 : 2'b00);
`ifdef DNU_WR_ITER_CNT_EN
    cnt = IW'(m_cnt);
`else
    cnt = '0;
`endif
    return {st, bz, act, mux, ld, {BN{ld}}, CW'(addr), act, rr, done, ab, cnt};
  endfunction

  task automatic check(string tag, logic [VW-1:0] exp);
    logic [VW-1:0] obs;
    obs = {state, busy, rom_port_fetch, ram_mux_en, ram_write_en, bank_we, wr_addr,
           iter_update, v3ib_rom_rst, iter_done, iter_aborted, iter_cnt};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge write_clk);
    #1;
  endtask

  // hold=0: request pulsed for one cycle; hold>0: request kept high for that many FINISH cycles.
  task automatic run_update(string tag, int len_in, int abort_at, int hold);
    logic [VW-1:0] exp_q[$];
    int eff, act_n, fin_n, n;
    bit ab;
    eff   = ((len_in == 0) || (len_in > LC)) ? LC : len_in;
    act_n = FL + eff;
    ab    = (abort_at >= 0) && (abort_at < act_n);
    if (ab) act_n = abort_at + 1;
    for (int i = 0; i < act_n; i++) begin
      if (i < FL) exp_q.push_back(exp_vec(1, 0, (i == FL - 1), 1'b0, 1'b0));
      else        exp_q.push_back(exp_vec(2, i - FL, 1'b1, 1'b0, 1'b0));
    end
    if (!ab && m_cnt < CMAX) m_cnt++;
    m_ab  = ab;
    fin_n = (hold > 0) ? hold : 1;
    for (int h = 0; h < fin_n; h++) exp_q.push_back(exp_vec(3, 0, 1'b0, (h == 0), ab));
    exp_q.push_back(exp_vec(0, 0, 1'b0, 1'b0, ab));
    iter_rqst = 1'b1;
    load_len  = (CW+1)'(len_in);
    n = 0;
    while (exp_q.size() > 0) begin
      step();
      check(tag, exp_q.pop_front());
      iter_rqst        = (hold > 0) && (n < act_n + fin_n - 1);
      iter_termination = ab && (n == abort_at);
      n++;
    end
    iter_termination = 1'b0;
  endtask

  initial begin
    int len_r, ab_r, hold_r;
    rstn = 1'b0; iter_rqst = 1'b0; iter_termination = 1'b0; load_len = '0;
    step();
    check("reset", exp_vec(0, 0, 1'b0, 1'b0, 1'b0));
    rstn = 1'b1;
    step();
    check("idle_after_reset", exp_vec(0, 0, 1'b0, 1'b0, 1'b0));

    run_update("full_len0", 0, -1, 0);
    run_update("len5", 5, -1, 0);
    run_update("abort_addr10", 30, FL + 10, 0);
    run_update("len1", 1, -1, 0);
    run_update("len_max", LC, -1, 0);
    run_update("len_over", LC + 1, -1, 0);
    run_update("abort_fetch", 2, 0, 0);
    run_update("abort_last_write", 4, FL + 3, 0);
    run_update("hold_finish", 4, -1, 3);
    run_update("retrigger", 3, -1, 0);

    // Rising edge while terminated is lost, even after termination drops.
    iter_termination = 1'b1;
    iter_rqst        = 1'b1;
    load_len         = '0;
    for (int i = 0; i < 3; i++) begin step(); check("blocked", exp_vec(0, 0, 1'b0, 1'b0, m_ab)); end
    iter_termination = 1'b0;
    for (int i = 0; i < 2; i++) begin step(); check("edge_lost", exp_vec(0, 0, 1'b0, 1'b0, m_ab)); end
    iter_rqst = 1'b0;
    step();
    check("blocked_idle", exp_vec(0, 0, 1'b0, 1'b0, m_ab));
    run_update("after_block", 6, -1, 0);

    // Asynchronous reset in the middle of LOAD, request still high at release.
    iter_rqst = 1'b1;
    load_len  = '0;
    for (int i = 0; i <= FL + 20; i++) begin
      step();
      if (i < FL) check("pre_rst_fetch", exp_vec(1, 0, (i == FL - 1), 1'b0, 1'b0));
      else        check("pre_rst_load", exp_vec(2, i - FL, 1'b1, 1'b0, 1'b0));
    end
    #2 rstn = 1'b0;
    m_cnt = 0;
    m_ab  = 1'b0;
    #1 check("async_reset", exp_vec(0, 0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin step(); check("in_reset", exp_vec(0, 0, 1'b0, 1'b0, 1'b0)); end
    rstn = 1'b1;
    run_update("start_at_release", 3, -1, 0);

    for (int k = 0; k < 12; k++) begin
      len_r  = $urandom_range(0, LC + 5);
      ab_r   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, FL + LC) : -1;
      hold_r = $urandom_range(0, 3);
      run_update("random", len_r, ab_r, hold_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
